// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the modular inverse unit.
// Used by the RTL and by the bench.
package mod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_HALF,
    OP_SUB
  } op_t;

  localparam int MOD_INV_WIDTH = 128;

  function automatic int mod_inv_max_cycles(input int w);
    return 4 * w + 4;
  endfunction

  localparam int MOD_INV_MAX_CYCLES =
    mod_inv_max_cycles(MOD_INV_WIDTH);

endpackage

// File: rtl/mod_half_sub.sv
// Coefficient update: x/2 mod p or x-y mod p.
// Inputs are assumed already reduced into [0, p).
module mod_half_sub
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  op_t              op,
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH:0]   y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH:0]   r
);

  logic [WIDTH:0] pe;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] half;
  logic [WIDTH:0] sub;

  // x < p, so x + p < 2^(WIDTH+1): no carry is lost.
  assign pe   = {1'b0, p};
  assign sum  = x + pe;
  assign diff = x - y;
  assign half = x[0] ? (sum >> 1) : (x >> 1);
  assign sub  = (x < y) ? (diff + pe) : diff;

  always_comb begin
    r = half;
    if (op == OP_SUB) r = sub;
  end

endmodule

// File: rtl/mod_inv.sv
// Binary extended-Euclid modular inverse, one step per cycle.
// Optional MOD_INV_ITER_CNT_EN adds a saturating RUN-cycle counter.
module mod_inv
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
`ifdef MOD_INV_ITER_CNT_EN
  output logic [15:0]      iter_cnt,
`endif
  output logic [WIDTH-1:0] res,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);
  localparam logic [WIDTH:0]   X_ONE = (WIDTH+1)'(1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH:0]   x1_q, x1_d;
  logic [WIDTH:0]   x2_q, x2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   x1_nx, x2_nx;
  op_t              x1_op, x2_op;
  logic             illegal;

`ifdef MOD_INV_ITER_CNT_EN
  logic [15:0] iter_q, iter_d;
  assign iter_cnt = iter_q;
`endif

  assign x1_op = u_q[0] ? OP_SUB : OP_HALF;
  assign x2_op = v_q[0] ? OP_SUB : OP_HALF;

  mod_half_sub #(.WIDTH(WIDTH)) u_x1 (
    .op (x1_op),
    .x  (x1_q),
    .y  (x2_q),
    .p  (p_q),
    .r  (x1_nx)
  );

  mod_half_sub #(.WIDTH(WIDTH)) u_x2 (
    .op (x2_op),
    .x  (x2_q),
    .y  (x1_q),
    .p  (p_q),
    .r  (x2_nx)
  );

  assign illegal = !p_q[0] || (p_q < THREE) ||
                   (a_q == '0) || (a_q >= p_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    res_d   = res_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
`ifdef MOD_INV_ITER_CNT_EN
    iter_d  = iter_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          p_d     = p;
          res_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
`ifdef MOD_INV_ITER_CNT_EN
          iter_d  = '0;
`endif
        end
      end
      CHECK: begin
        if (illegal) begin
          res_d   = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          u_d     = a_q;
          v_d     = p_q;
          x1_d    = X_ONE;
          x2_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MOD_INV_ITER_CNT_EN
        if (iter_q != 16'hFFFF) iter_d = iter_q + 16'd1;
`endif
        // Exit is decided on the pre-step values.
        if (u_q == ONE || v_q == ONE ||
            u_q == '0 || v_q == '0) begin
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
          if (u_q == ONE) begin
            res_d = x1_q[WIDTH-1:0];
          end else if (v_q == ONE) begin
            res_d = x2_q[WIDTH-1:0];
          end else begin
            res_d = '0;
            err_d = 1'b1;
          end
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_nx;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_nx;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_nx;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      p_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MOD_INV_ITER_CNT_EN
      iter_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef MOD_INV_ITER_CNT_EN
      iter_q  <= iter_d;
`endif
    end
  end

  assign res   = res_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mod_inv.sv
// Scenario bench for mod_inv (WIDTH=128, default build).
// Expected results are queued at stimulus time, popped on valid.
module tb_mod_inv;
  import mod_arith_pkg::*;

  localparam int W = 128;
  localparam int LIM = MOD_INV_MAX_CYCLES + 8;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] p;
  logic [W-1:0] res;
  logic         valid;
  logic         busy;
  logic         err;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  mod_inv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .p     (p),
    .res   (res),
    .valid (valid),
    .busy  (busy),
    .err   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic start_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tp);
    @(negedge clk);
    a     = ta;
    p     = tp;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] r, input logic e);
    exp_t x;
    x.res = r;
    x.err = e;
    sb.push_back(x);
  endtask

  // Counts edges after the accept edge until valid; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < LIM) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  // Independent reference: classic extended Euclid on small values.
  function automatic exp_t ref_inv(input longint ta,
                                   input longint tp);
    longint t, nt, r, nr, q, tmp;
    exp_t   x;
    t = 0; nt = 1; r = tp; nr = ta;
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (r != 1) begin
      x.res = '0;
      x.err = 1'b1;
    end else begin
      if (t < 0) t += tp;
      x.res = W'(t);
      x.err = 1'b0;
    end
    return x;
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = W'(3);
    p     = W'(7);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({res, valid, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: res=%0h v=%b b=%b e=%b want 0",
               res, valid, busy, err);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: v=%b b=%b want 0 0", valid, busy);
    end
  endtask

  task automatic test_basic();
    int   cyc;
    exp_t e;
    start_op(W'(3), W'(7));
    push(W'(5), 1'b0);
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_accept: b=%b v=%b want 1 0", busy, valid);
    end
    wait_done(cyc);
    vectors++;
    if (valid !== 1'b1 || cyc > MOD_INV_MAX_CYCLES) begin
      miscompares++;
      $display("FAIL basic_latency: cycles=%0d max=%0d",
               cyc, MOD_INV_MAX_CYCLES);
    end
    e = sb.pop_front();
    vectors++;
    if (res !== e.res || err !== e.err || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_3_7: res=%0d err=%b b=%b want %0d %b 0",
               res, err, busy, e.res, e.err);
    end
  endtask

  task automatic test_back_to_back();
    int           cyc;
    exp_t         e;
    logic [W-1:0] big;
    logic [W-1:0] want;
    big  = {1'b0, {(W-1){1'b1}}};
    want = W'(1) << 126;
    start_op(W'(10), W'(17));
    push(W'(12), 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (valid !== 1'b1 || res !== e.res || err !== e.err) begin
      miscompares++;
      $display("FAIL b2b_10_17: v=%b res=%0d err=%b want %0d %b",
               valid, res, err, e.res, e.err);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b1 || res !== W'(12)) begin
      miscompares++;
      $display("FAIL b2b_hold: v=%b res=%0d want 1 12", valid, res);
    end
    start_op(W'(2), big);
    push(want, 1'b0);
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: v=%b b=%b want 0 1", valid, busy);
    end
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (valid !== 1'b1 || res !== e.res || err !== e.err) begin
      miscompares++;
      $display("FAIL b2b_mersenne: res=%0h err=%b want %0h %b",
               res, err, e.res, e.err);
    end
  endtask

  task automatic test_errors();
    int           cyc;
    exp_t         e;
    logic [W-1:0] ta[4];
    logic [W-1:0] tp[4];
    int           cmax[4];
    ta = '{W'(6), W'(0), W'(3), W'(7)};
    tp = '{W'(9), W'(7), W'(8), W'(7)};
    cmax = '{MOD_INV_MAX_CYCLES, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tp[i]);
      push('0, 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (valid !== 1'b1 || cyc > cmax[i]) begin
        miscompares++;
        $display("FAIL err_latency[%0d]: cycles=%0d max=%0d",
                 i, cyc, cmax[i]);
      end
      vectors++;
      if (res !== e.res || err !== e.err) begin
        miscompares++;
        $display("FAIL err_case[%0d]: res=%0d err=%b want %0d %b",
                 i, res, err, e.res, e.err);
      end
    end
  endtask

  task automatic test_ignore_restart();
    int   cyc;
    exp_t e;
    start_op(W'(10), W'(17));
    push(W'(12), 1'b0);
    repeat (2) @(posedge clk);
    start_op(W'(3), W'(7));
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_busy: b=%b v=%b want 1 0", busy, valid);
    end
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (valid !== 1'b1 || res !== e.res || err !== e.err) begin
      miscompares++;
      $display("FAIL ignore_result: res=%0d err=%b want %0d %b",
               res, err, e.res, e.err);
    end
  endtask

  task automatic test_mid_run_reset();
    int   cyc;
    exp_t e;
    start_op(W'(10), W'(17));
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({res, valid, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL midrst_async: res=%0h v=%b b=%b e=%b want 0",
               res, valid, busy, err);
    end
    @(negedge clk);
    start = 1'b1;
    a     = W'(3);
    p     = W'(7);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_start_ignored: b=%b v=%b want 0 0",
               busy, valid);
    end
    start_op(W'(3), W'(7));
    push(W'(5), 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    vectors++;
    if (valid !== 1'b1 || res !== e.res || err !== e.err) begin
      miscompares++;
      $display("FAIL midrst_recover: res=%0d err=%b want %0d %b",
               res, err, e.res, e.err);
    end
  endtask

  task automatic test_random();
    int           cyc;
    int           tp;
    int           ta;
    exp_t         e;
    logic [255:0] prod;
    for (int i = 0; i < 1000; i++) begin
      tp = 2 * $urandom_range(1, 511) + 1;
      ta = $urandom_range(1, tp - 1);
      start_op(W'(ta), W'(tp));
      push(ref_inv(longint'(ta), longint'(tp)).res,
           ref_inv(longint'(ta), longint'(tp)).err);
      wait_done(cyc);
      e = sb.pop_front();
      vectors++;
      if (valid !== 1'b1 || res !== e.res || err !== e.err) begin
        miscompares++;
        $display("FAIL rand[%0d] a=%0d p=%0d: res=%0d err=%b want %0d %b",
                 i, ta, tp, res, err, e.res, e.err);
      end
      if (err === 1'b0) begin
        prod = ({128'b0, W'(ta)} * {128'b0, res}) % 256'(tp);
        vectors++;
        if (prod !== 256'd1 || res >= W'(tp)) begin
          miscompares++;
          $display("FAIL rand_prop[%0d] a=%0d p=%0d: res=%0d a*res%%p=%0d",
                   i, ta, tp, res, prod);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    p           = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_ignore_restart();
    test_mid_run_reset();
    test_random();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: mod_inv

Interface
REQ-001 The module SHALL have parameter WIDTH, default 128, giving the operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; operands are sampled on the cycle it is accepted.
REQ-005 a  input  WIDTH  value to invert.
REQ-006 p  input  WIDTH  modulus.
REQ-007 res  output  WIDTH  modular inverse of a mod p.
REQ-008 valid  output  1  res/err are final; held until the next accepted start.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 err  output  1  no inverse exists or the operands are illegal; qualified by valid.

Function
REQ-011 The state machine SHALL have four states: IDLE, CHECK, RUN and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; the accept cycle latches a and p, clears valid and err, sets busy and enters CHECK.
REQ-013 start asserted in CHECK or RUN SHALL be ignored with no effect on the computation.
REQ-014 CHECK SHALL take one cycle and SHALL go to DONE with err=1, res=0 if p is even, p<3, a==0 or a>=p; otherwise it SHALL go to RUN.
REQ-015 On entry to RUN the registers SHALL be u=a, v=p, x1=1, x2=0; x1 and x2 SHALL be WIDTH+1 bits wide so that x+p does not overflow.
REQ-016 Each RUN cycle SHALL perform exactly one step, chosen by the first matching condition:
- u even: u=u/2; x1=x1/2 if x1 is even, else (x1+p)/2.
- otherwise, v even: the same operation on v and x2.
- otherwise, u>=v: u=u-v; x1=x1-x2, adding p if the result is negative.
- otherwise: v=v-u; x2=x2-x1, adding p if the result is negative.
REQ-017 RUN SHALL exit to DONE on the first cycle in which u==1 (res=x1), v==1 (res=x2), or u==0 or v==0 (err=1, res=0); the exit test SHALL be made on the register values before the step.
REQ-018 In DONE, valid SHALL be 1 and busy 0; res and err SHALL be stable until the next accepted start.
REQ-019 The number of cycles from the start-accept edge to valid rising SHALL be at most 4*WIDTH+4.
REQ-020 Every non-error res SHALL satisfy res<p and (a*res) mod p == 1.
REQ-021 start asserted in DONE SHALL begin a new operation, with valid falling on the following edge.

Reset
REQ-022 rst SHALL immediately force IDLE, res=0, valid=0, busy=0 and err=0, including mid-RUN; no partial result SHALL be exposed.
REQ-023 start asserted while rst is high SHALL be ignored; the first start accepted after reset release SHALL operate normally.

Configuration
REQ-024 With macro MOD_INV_ITER_CNT_EN defined, the module SHALL add an output iter_cnt[15:0] that is cleared on start accept, incremented once per RUN cycle, saturates at 16'hFFFF and holds its value in DONE.
REQ-025 Without MOD_INV_ITER_CNT_EN, iter_cnt and its counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 A shared package mod_arith_pkg SHALL hold the FSM state typedef (IDLE, CHECK, RUN, DONE) and the constant MOD_INV_MAX_CYCLES = 4*WIDTH+4, for use by the RTL and the bench.
REQ-027 One sub-module SHALL be used: mod_half_sub, a combinational block implementing the x/2-mod-p and x-y-mod-p update of REQ-016, instantiated twice (once for x1, once for x2).

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- a=3, p=7 -> valid within MOD_INV_MAX_CYCLES, res=5, err=0.
- a=10, p=17 -> res=12, err=0; back-to-back start in DONE with a=2, p=2^127-1 -> res=2^126.
- a=6, p=9 -> err=1, res=0; a=0, p=7 -> err=1 after CHECK (start + 2 cycles); p=8 -> err=1.
- start re-pulsed mid-RUN with different a -> ignored; the original result is returned.
- rst asserted mid-RUN -> outputs 0 at once; a new start with a=3, p=7 then yields res=5.
- random odd p, random a<p (1000 cases) -> (a*res) mod p == 1 whenever err=0.
